// File: rtl/spi_slave_gen_if.sv
// spi_slave_gen_if -- bundle of the SPI pins and the parallel tx/rx handshake
// for spi_slave_gen. The slave modport is the design's view; the master
// modport is the view of whatever drives the SPI bus and the tx holding register.
interface spi_slave_gen_if #(
    parameter int DATA_W = 8
);
    logic              sclk_in;
    logic              mosi_in;
    logic              ss_in;
    logic              stutter_in;
    logic              miso;
    logic [DATA_W-1:0] tx_data;
    logic              tx_load;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              busy;

    modport slave (
        input  sclk_in, mosi_in, ss_in, stutter_in, tx_data, tx_load,
        output miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output sclk_in, mosi_in, ss_in, stutter_in, tx_data, tx_load,
        input  miso, tx_ready, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_slave_gen.sv
// spi_slave_gen -- oversampling SPI slave. All SPI inputs are synchronised
// into clk and edges are found by comparing the synchronised sclk against
// its previous value, so sclk must be slow relative to clk.
// Optional feature: define SPI_SLAVE_GEN_LSB_FIRST_EN to shift rx and tx
// LSB-first; default build is MSB-first.
module spi_slave_gen #(
    parameter int DATA_W      = 8,
    parameter int CPOL        = 0,
    parameter int CPHA        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    spi_slave_gen_if.slave bus
);

    localparam int                 CNT_W        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int                 NS           = SYNC_STAGES;
    localparam logic               IDLE         = (CPOL != 0) ? 1'b1 : 1'b0;
    localparam logic               SAMPLE_TRAIL = (CPHA != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0]   CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0]  WORD_ZERO    = {DATA_W{1'b0}};

`ifdef SPI_SLAVE_GEN_LSB_FIRST_EN
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return {b, w[DATA_W-1:1]};
    endfunction
`else
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return {w[DATA_W-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return {w[DATA_W-2:0], b};
    endfunction
`endif

    // Synchronisers; index 0 samples the pin, index NS-1 is the usable value.
    logic [NS-1:0]     sclk_sync_q, sclk_sync_d;
    logic [NS-1:0]     mosi_sync_q, mosi_sync_d;
    logic [NS-1:0]     ss_sync_q,   ss_sync_d;
    logic [NS-1:0]     stut_sync_q, stut_sync_d;
    // Marks which ss stages hold a value really taken from the pin since reset.
    logic [NS-1:0]     ss_vld_q,    ss_vld_d;

    logic              sclk_prev_q,   sclk_prev_d;
    logic              ss_act_prev_q, ss_act_prev_d;
    logic              armed_q,       armed_d;
    logic              fresh_q,       fresh_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;
    logic [DATA_W-1:0] rx_sh_q,       rx_sh_d;
    logic [DATA_W-1:0] tx_sh_q,       tx_sh_d;
    logic [DATA_W-1:0] hold_q,        hold_d;
    logic              tx_ready_q,    tx_ready_d;
    logic              miso_q,        miso_d;
    logic [DATA_W-1:0] rx_data_q,     rx_data_d;
    logic              rx_valid_q,    rx_valid_d;
    logic              tx_underrun_q, tx_underrun_d;
    logic              busy_q,        busy_d;

    logic              stall_s, sclk_s, mosi_s, ss_s, ss_act_s, start_act_s;
    logic              lead_s, trail_s, sample_edge_s, shift_edge_s, load_now_s;
    logic [DATA_W-1:0] word_s, src_s, rx_new_s;

    // Next-state logic: edge detection, shifters, bit counter and holding register.
    always_comb begin
        stall_s       = stut_sync_q[NS-1];
        sclk_s        = sclk_sync_q[NS-1];
        mosi_s        = mosi_sync_q[NS-1];
        ss_s          = ss_sync_q[NS-1];
        // After reset ss only counts once it has been seen inactive, so a
        // select that was already low during reset is never treated as a word.
        ss_act_s      = armed_q & ~ss_s;
        start_act_s   = ~stall_s & ss_act_s & ~ss_act_prev_q;
        lead_s        = ~stall_s & ss_act_s & (sclk_prev_q == IDLE) & (sclk_s != IDLE);
        trail_s       = ~stall_s & ss_act_s & (sclk_prev_q != IDLE) & (sclk_s == IDLE);
        sample_edge_s = SAMPLE_TRAIL ? trail_s : lead_s;
        shift_edge_s  = SAMPLE_TRAIL ? lead_s  : trail_s;
        // A wrapped word is started lazily on the first shift edge of the next
        // word, so a transfer that simply ends after its last bit does not
        // consume the holding register or report an underrun. fresh_q marks the
        // CPHA=1 word already loaded at ss activation.
        load_now_s    = start_act_s | (shift_edge_s & (cnt_q == CNT_ZERO) & ~fresh_q);
        word_s        = tx_ready_q ? WORD_ZERO : hold_q;
        src_s         = load_now_s ? word_s : tx_sh_q;
        rx_new_s      = shift_in(rx_sh_q, mosi_s);

        sclk_prev_d   = sclk_prev_q;
        ss_act_prev_d = ss_act_prev_q;
        fresh_d       = fresh_q;
        cnt_d         = cnt_q;
        rx_sh_d       = rx_sh_q;
        tx_sh_d       = tx_sh_q;
        hold_d        = hold_q;
        tx_ready_d    = tx_ready_q;
        miso_d        = miso_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        busy_d        = ss_act_s;
        armed_d       = armed_q | (ss_vld_q[NS-1] & ss_s);

        stut_sync_d   = {stut_sync_q[NS-2:0], bus.stutter_in};
        if (stall_s) begin
            sclk_sync_d = {sclk_sync_q[NS-1:1], bus.sclk_in};
            mosi_sync_d = {mosi_sync_q[NS-1:1], bus.mosi_in};
            ss_sync_d   = {ss_sync_q[NS-1:1],   bus.ss_in};
            ss_vld_d    = {ss_vld_q[NS-1:1],    1'b1};
        end else begin
            sclk_sync_d   = {sclk_sync_q[NS-2:0], bus.sclk_in};
            mosi_sync_d   = {mosi_sync_q[NS-2:0], bus.mosi_in};
            ss_sync_d     = {ss_sync_q[NS-2:0],   bus.ss_in};
            ss_vld_d      = {ss_vld_q[NS-2:0],    1'b1};
            sclk_prev_d   = sclk_s;
            ss_act_prev_d = ss_act_s;
        end

        if (stall_s) begin
            fresh_d = fresh_q;
        end else if (!ss_act_s) begin
            cnt_d   = CNT_ZERO;
            rx_sh_d = WORD_ZERO;
            tx_sh_d = WORD_ZERO;
            miso_d  = 1'b0;
            fresh_d = 1'b0;
        end else begin
            if (sample_edge_s) begin
                rx_sh_d = rx_new_s;
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = CNT_ZERO;
                    rx_data_d  = rx_new_s;
                    rx_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_d = cnt_q;
            end

            if (start_act_s) begin
                if (SAMPLE_TRAIL) begin
                    tx_sh_d = word_s;
                    miso_d  = 1'b0;
                    fresh_d = 1'b1;
                end else begin
                    tx_sh_d = shift_out(word_s);
                    miso_d  = first_bit(word_s);
                    fresh_d = 1'b0;
                end
            end else if (shift_edge_s) begin
                tx_sh_d = shift_out(src_s);
                miso_d  = first_bit(src_s);
                fresh_d = 1'b0;
            end else begin
                tx_sh_d = tx_sh_q;
            end
        end

        // Word start consumes the holding register before a same-cycle load
        // is accepted, so a load racing an empty-register start is kept.
        if (load_now_s) begin
            tx_underrun_d = tx_ready_q;
            tx_ready_d    = 1'b1;
        end else begin
            tx_underrun_d = 1'b0;
        end

        if (bus.tx_load && tx_ready_q) begin
            hold_d     = bus.tx_data;
            tx_ready_d = 1'b0;
        end else begin
            hold_d = hold_q;
        end
    end

    // State registers with synchronous reset to the idle bus condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q   <= {NS{IDLE}};
            mosi_sync_q   <= {NS{1'b0}};
            ss_sync_q     <= {NS{1'b1}};
            stut_sync_q   <= {NS{1'b0}};
            ss_vld_q      <= {NS{1'b0}};
            sclk_prev_q   <= IDLE;
            ss_act_prev_q <= 1'b0;
            armed_q       <= 1'b0;
            fresh_q       <= 1'b0;
            cnt_q         <= CNT_ZERO;
            rx_sh_q       <= WORD_ZERO;
            tx_sh_q       <= WORD_ZERO;
            hold_q        <= WORD_ZERO;
            tx_ready_q    <= 1'b1;
            miso_q        <= 1'b0;
            rx_data_q     <= WORD_ZERO;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            ss_sync_q     <= ss_sync_d;
            stut_sync_q   <= stut_sync_d;
            ss_vld_q      <= ss_vld_d;
            sclk_prev_q   <= sclk_prev_d;
            ss_act_prev_q <= ss_act_prev_d;
            armed_q       <= armed_d;
            fresh_q       <= fresh_d;
            cnt_q         <= cnt_d;
            rx_sh_q       <= rx_sh_d;
            tx_sh_q       <= tx_sh_d;
            hold_q        <= hold_d;
            tx_ready_q    <= tx_ready_d;
            miso_q        <= miso_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.miso        = miso_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: instance a is mode 0 / 8 bit,
// instance b is CPOL=1 CPHA=1 / 16 bit. Bit order follows
// SPI_SLAVE_GEN_LSB_FIRST_EN when defined.
module tb_spi_slave_gen;

    localparam int HALF = 8;
`ifdef SPI_SLAVE_GEN_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_slave_gen_if #(.DATA_W(8))  ifa ();
    spi_slave_gen_if #(.DATA_W(16)) ifb ();

    spi_slave_gen #(.DATA_W(8), .CPOL(0), .CPHA(0), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa)
    );
    spi_slave_gen #(.DATA_W(16), .CPOL(1), .CPHA(1), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          cyc     = 0;
    int          rva_cnt = 0;
    int          rva_cyc = 0;
    logic [7:0]  rva_last = 8'h00;
    int          uda_cnt = 0;
    int          rvb_cnt = 0;
    int          udb_cnt = 0;
    logic [15:0] rvb_log [0:3];

    int          last_lead_a = 0;
    logic [7:0]  mi_a = 8'h00;
    logic        first_a = 1'b0;
    logic [15:0] mi_b = 16'h0000;
    int          base_rv = 0;
    int          base_ud = 0;

    // Free-running cycle count for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitors sampled on the falling edge.
    always @(negedge clk) begin
        if (ifa.rx_valid === 1'b1) begin
            rva_cnt  <= rva_cnt + 1;
            rva_last <= ifa.rx_data;
            rva_cyc  <= cyc;
        end
        if (ifa.tx_underrun === 1'b1) uda_cnt <= uda_cnt + 1;
        if (ifb.rx_valid === 1'b1) begin
            if (rvb_cnt < 4) rvb_log[rvb_cnt] <= ifb.rx_data;
            rvb_cnt <= rvb_cnt + 1;
        end
        if (ifb.tx_underrun === 1'b1) udb_cnt <= udb_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);
        ifa.tx_data = v;
        ifa.tx_load = 1'b1;
        tick(1);
        ifa.tx_load = 1'b0;
    endtask

    task automatic load_b(input logic [15:0] v);
        ifb.tx_data = v;
        ifb.tx_load = 1'b1;
        tick(1);
        ifb.tx_load = 1'b0;
    endtask

    // Mode-0 master: bits [from, upto) of one 8-bit word, miso captured into mi_a.
    task automatic xfer_a(input logic [7:0] mo, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            int idx;
            idx = LSB ? i : 7 - i;
            ifa.mosi_in = mo[idx];
            tick(HALF);
            mi_a[idx] = ifa.miso;
            if (i == 0) first_a = ifa.miso;
            ifa.sclk_in = 1'b1;
            last_lead_a = cyc;
            tick(HALF);
            ifa.sclk_in = 1'b0;
        end
        tick(HALF);
    endtask

    // CPOL=1 CPHA=1 master: one 16-bit word, miso captured into mi_b.
    task automatic xfer_b(input logic [15:0] mo);
        for (int i = 0; i < 16; i++) begin
            int idx;
            idx = LSB ? i : 15 - i;
            ifb.sclk_in = 1'b0;
            ifb.mosi_in = mo[idx];
            tick(HALF);
            mi_b[idx] = ifb.miso;
            ifb.sclk_in = 1'b1;
            tick(HALF);
        end
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_miso"},     32'(ifa.miso),        32'h0);
        chk({tag, "_tx_ready"}, 32'(ifa.tx_ready),    32'h1);
        chk({tag, "_rx_data"},  32'(ifa.rx_data),     32'h0);
        chk({tag, "_rx_valid"}, 32'(ifa.rx_valid),    32'h0);
        chk({tag, "_underrun"}, 32'(ifa.tx_underrun), 32'h0);
        chk({tag, "_busy"},     32'(ifa.busy),        32'h0);
    endtask

    initial begin
        ifa.sclk_in = 1'b0; ifa.mosi_in = 1'b0; ifa.ss_in = 1'b1; ifa.stutter_in = 1'b0;
        ifa.tx_data = 8'h00; ifa.tx_load = 1'b0;
        ifb.sclk_in = 1'b1; ifb.mosi_in = 1'b0; ifb.ss_in = 1'b1; ifb.stutter_in = 1'b0;
        ifb.tx_data = 16'h0000; ifb.tx_load = 1'b0;

        // Reset values.
        rst = 1'b1;
        tick(3);
        chk_reset_a("rst");
        rst = 1'b0;
        tick(6);

        // CPOL=1 CPHA=1, two back-to-back words under one select.
        load_b(16'hCAFE);
        base_ud = udb_cnt;
        ifb.ss_in = 1'b0;
        tick(HALF);
        chk("b_ready_after_start", 32'(ifb.tx_ready), 32'h1);
        load_b(16'h0F0F);
        mi_b = 16'h0000;
        xfer_b(16'h1234);
        chk("b_miso_word0", 32'(mi_b), 32'hCAFE);
        mi_b = 16'h0000;
        xfer_b(16'hBEEF);
        tick(HALF);
        chk("b_miso_word1", 32'(mi_b), 32'h0F0F);
        chk("b_rx_count", 32'(rvb_cnt), 32'd2);
        chk("b_rx_word0", 32'(rvb_log[0]), 32'h1234);
        chk("b_rx_word1", 32'(rvb_log[1]), 32'hBEEF);
        chk("b_no_underrun", 32'(udb_cnt - base_ud), 32'd0);
        ifb.ss_in = 1'b1;
        tick(HALF);

        // Mode 0 basic word: tx 0xA5, master sends 0x3C.
        load_a(8'hA5);
        chk("a_ready_after_load", 32'(ifa.tx_ready), 32'h0);
        ifa.ss_in = 1'b0;
        tick(HALF);
        chk("a_busy_active", 32'(ifa.busy), 32'h1);
        base_rv = rva_cnt;
        mi_a = 8'h00;
        xfer_a(8'h3C, 0, 8);
        chk("a_miso_bits", 32'(mi_a), 32'hA5);
        chk("a_rx_count", 32'(rva_cnt - base_rv), 32'd1);
        chk("a_rx_data", 32'(rva_last), 32'h3C);
        chk("a_rx_latency", 32'(rva_cyc - last_lead_a), 32'd3);
        ifa.ss_in = 1'b1;
        tick(HALF);
        chk("a_busy_idle", 32'(ifa.busy), 32'h0);
        chk("a_miso_idle", 32'(ifa.miso), 32'h0);

        // Underrun: nothing loaded before select.
        base_ud = uda_cnt;
        ifa.ss_in = 1'b0;
        tick(HALF);
        chk("ur_pulse", 32'(uda_cnt - base_ud), 32'd1);
        mi_a = 8'hFF;
        xfer_a(8'h55, 0, 8);
        chk("ur_miso_zero", 32'(mi_a), 32'h00);
        chk("ur_tx_ready", 32'(ifa.tx_ready), 32'h1);
        ifa.ss_in = 1'b1;
        tick(HALF);

        // Abort after 5 bits, holding register survives, then full word 0x81.
        ifa.ss_in = 1'b0;
        tick(HALF);
        load_a(8'h77);
        base_rv = rva_cnt;
        xfer_a(8'hFF, 0, 5);
        ifa.ss_in = 1'b1;
        tick(HALF);
        chk("abort_no_rx", 32'(rva_cnt - base_rv), 32'd0);
        chk("abort_hold_kept", 32'(ifa.tx_ready), 32'h0);
        chk("abort_miso_zero", 32'(ifa.miso), 32'h0);
        ifa.ss_in = 1'b0;
        tick(HALF);
        mi_a = 8'h00;
        xfer_a(8'h81, 0, 8);
        chk("abort_next_count", 32'(rva_cnt - base_rv), 32'd1);
        chk("abort_next_rx", 32'(rva_last), 32'h81);
        chk("abort_next_miso", 32'(mi_a), 32'h77);
        ifa.ss_in = 1'b1;
        tick(HALF);

        // Stutter for 20 cycles mid-word with sclk held.
        load_a(8'hC3);
        ifa.ss_in = 1'b0;
        tick(HALF);
        base_rv = rva_cnt;
        mi_a = 8'h00;
        xfer_a(8'h5A, 0, 3);
        ifa.stutter_in = 1'b1;
        tick(20);
        ifa.stutter_in = 1'b0;
        tick(HALF);
        chk("stut_no_early_rx", 32'(rva_cnt - base_rv), 32'd0);
        xfer_a(8'h5A, 3, 8);
        chk("stut_rx_count", 32'(rva_cnt - base_rv), 32'd1);
        chk("stut_rx_data", 32'(rva_last), 32'h5A);
        chk("stut_miso", 32'(mi_a), 32'hC3);
        ifa.ss_in = 1'b1;
        tick(HALF);

        // Reset mid-word, then no reception until a fresh select.
        load_a(8'h3F);
        ifa.ss_in = 1'b0;
        tick(HALF);
        load_a(8'h11);
        xfer_a(8'hFF, 0, 4);
        chk("mid_busy", 32'(ifa.busy), 32'h1);
        rst = 1'b1;
        tick(1);
        chk_reset_a("midrst");
        rst = 1'b0;
        tick(HALF);
        base_rv = rva_cnt;
        xfer_a(8'hFF, 0, 8);
        chk("midrst_no_rx", 32'(rva_cnt - base_rv), 32'd0);
        chk("midrst_not_busy", 32'(ifa.busy), 32'h0);
        ifa.ss_in = 1'b1;
        tick(HALF);
        ifa.ss_in = 1'b0;
        tick(HALF);
        mi_a = 8'hFF;
        xfer_a(8'h96, 0, 8);
        chk("fresh_rx_count", 32'(rva_cnt - base_rv), 32'd1);
        chk("fresh_rx_data", 32'(rva_last), 32'h96);
        chk("fresh_miso_zero", 32'(mi_a), 32'h00);
        ifa.ss_in = 1'b1;
        tick(HALF);

        // Bit-order check: tx 0x01, master sends 0x80.
        load_a(8'h01);
        ifa.ss_in = 1'b0;
        tick(HALF);
        mi_a = 8'h00;
        xfer_a(8'h80, 0, 8);
        chk("order_first_bit", 32'(first_a), LSB ? 32'h1 : 32'h0);
        chk("order_miso_word", 32'(mi_a), 32'h01);
        chk("order_rx_data", 32'(rva_last), 32'h80);
        ifa.ss_in = 1'b1;
        tick(HALF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
